// File: rtl/qport_serial_tx.sv
// Q-register output port: buffers CPU writes to Q in a small FIFO and sends
// each byte as an 8N1 frame (start, 8 data bits LSB first, stop) on txd.
`timescale 1ns/1ps
module qport_serial_tx #(
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   qStrobe,
  input  logic [7:0]             qData,
  output logic                   txd,
  output logic                   busy,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] level
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             r_overflow;
  logic [7:0]       r_shift;
  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_bit_idx;
  logic             w_pop;
  logic             w_push;
  logic             w_div_done;
  logic             w_txd;
  logic             w_busy;

  assign w_div_done = (r_div == DIV_W'(CLKS_PER_BIT - 1));
  // A full FIFO still accepts a byte when the head leaves at the same edge.
  assign w_push     = qStrobe && ((r_level < LVL_W'(DEPTH)) || w_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_pop) w_state_next = S_START;
      S_START: if (w_div_done) w_state_next = S_DATA;
      S_DATA:  if (w_div_done && (r_bit_idx == 3'd7)) w_state_next = S_STOP;
      S_STOP:  if (w_div_done) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_txd  = 1'b1;
    w_busy = 1'b1;
    w_pop  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        w_pop  = (r_level != '0);
      end
      S_START: w_txd = 1'b0;
      S_DATA:  w_txd = r_shift[0];
      default: w_txd = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_level <= r_level + LVL_W'(1);
      else if (!w_push && w_pop) r_level <= r_level - LVL_W'(1);
      if (qStrobe && !w_push) r_overflow <= 1'b1;
    end
  end

  // Storage has no reset so it can map onto RAM; validity is tracked by r_level.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= qData;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift   <= 8'hFF;
      r_div     <= '0;
      r_bit_idx <= '0;
    end else begin
      if (w_pop)
        r_shift <= r_mem[r_rd_ptr];
      else if ((r_state == S_DATA) && w_div_done)
        r_shift <= {1'b1, r_shift[7:1]};

      if ((r_state == S_IDLE) || w_div_done) r_div <= '0;
      else                                   r_div <= r_div + DIV_W'(1);

      if (r_state != S_DATA) r_bit_idx <= '0;
      else if (w_div_done)   r_bit_idx <= r_bit_idx + 3'd1;
    end
  end

  assign txd      = w_txd;
  assign busy     = w_busy;
  assign full     = (r_level == LVL_W'(DEPTH));
  assign empty    = (r_level == '0);
  assign overflow = r_overflow;
  assign level    = r_level;
endmodule

// File: tb/tb_qport_serial_tx.sv
// Bench for qport_serial_tx: queue-level reference model, per-cycle line check
// and a frame-decoding monitor that scores bytes against the expected queue.
`timescale 1ns/1ps
module tb_qport_serial_tx;
  localparam int DEPTH = 4;
  localparam int C     = 4;
  localparam int FRAME = 10 * C;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       qStrobe = 1'b0;
  logic [7:0] qData = 8'h00;
  logic       txd, busy, full, empty, overflow;
  logic [2:0] level;

  qport_serial_tx #(.DEPTH(DEPTH), .CLKS_PER_BIT(C)) dut (
    .clk(clk), .reset(reset), .qStrobe(qStrobe), .qData(qData),
    .txd(txd), .busy(busy), .full(full), .empty(empty),
    .overflow(overflow), .level(level)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, transmitter as a remaining-cycle count.
  logic [7:0] m_q[$];
  logic [7:0] exp_q[$];
  int         m_rem = 0;
  bit         m_ov = 1'b0;
  logic [7:0] m_cur = 8'h00;

  initial begin
    bit pop;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_q.delete();
        exp_q.delete();
        m_rem = 0;
        m_ov  = 1'b0;
      end else begin
        pop = (m_rem == 0) && (m_q.size() > 0);
        if (pop) begin
          m_cur = m_q.pop_front();
          exp_q.push_back(m_cur);
          m_rem = FRAME;
        end else if (m_rem > 0) begin
          m_rem--;
        end
        if (qStrobe) begin
          if (m_q.size() < DEPTH) m_q.push_back(qData);
          else m_ov = 1'b1;
        end
      end
    end
  end

  function automatic logic exp_txd();
    int pos, b;
    if (m_rem == 0) return 1'b1;
    pos = FRAME - m_rem;
    b   = pos / C;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_cur[b-1];
  endfunction

  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        e = {exp_txd(), (m_rem != 0), (m_q.size() == DEPTH), (m_q.size() == 0), m_ov, 3'(m_q.size())};
        chk("cycle_outputs", {txd, busy, full, empty, overflow, level}, e);
      end
    end
  end

  initial begin
    int cnt, b;
    bit act;
    logic [7:0] sh;
    act = 1'b0;
    cnt = 0;
    sh  = 8'h00;
    forever begin
      @(negedge clk);
      if (reset) act = 1'b0;
      else if (!act) begin
        if (txd == 1'b0) begin act = 1'b1; cnt = 0; end
      end else cnt++;
      if (act && !reset && ((cnt % C) == C / 2)) begin
        b = cnt / C;
        if (b == 0) chk("start_bit", txd, 1'b0);
        else if (b <= 8) sh[b-1] = txd;
        else begin
          chk("stop_bit", txd, 1'b1);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL frame_unexpected: got %0h expected no frame at %0t", sh, $time);
          end else begin
            chk("frame_data", sh, exp_q.pop_front());
          end
          act = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    qStrobe = 1'b1;
    qData   = d;
  endtask

  task automatic stop_strobe();
    @(negedge clk);
    qStrobe = 1'b0;
    qData   = $urandom;
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ((m_rem == 0) && (m_q.size() == 0)) break;
    end
    chk("drain_done", (i < 3000), 1'b1);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int i;
    repeat (3) @(negedge clk);
    chk("reset_txd", txd, 1'b1);
    chk("reset_flags", {busy, full, empty, overflow, level}, {1'b0, 1'b0, 1'b1, 1'b0, 3'd0});
    reset = 1'b0;
    repeat (50) @(negedge clk);
    chk("idle_after_50", {txd, busy, empty, level}, {1'b1, 1'b0, 1'b1, 3'd0});

    send(8'hA5);
    stop_strobe();
    chk("a5_level_after_N", level, 3'd1);
    chk("a5_txd_after_N", txd, 1'b1);
    @(negedge clk);
    chk("a5_txd_after_N1", txd, 1'b0);
    chk("a5_level_after_N1", level, 3'd0);
    repeat (39) @(negedge clk);
    chk("a5_busy_at_N40", busy, 1'b1);
    @(negedge clk);
    chk("a5_busy_at_N41", busy, 1'b0);
    drain();

    send(8'h01); send(8'h02); send(8'h03);
    stop_strobe();
    drain();
    chk("order_overflow", overflow, 1'b0);

    for (int k = 0; k < 6; k++) send(8'h10 + 8'(k));
    stop_strobe();
    chk("ovf_full", full, 1'b1);
    chk("ovf_flag", overflow, 1'b1);
    drain();
    chk("ovf_sticky", {overflow, empty}, 2'b11);

    do_reset();
    send(8'h55);
    for (int k = 0; k < 4; k++) send(8'h60 + 8'(k));
    stop_strobe();
    chk("pp_full", level, 3'd4);
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (m_rem == 0) break;
    end
    chk("pp_idle_reached", (i < 200), 1'b1);
    chk("pp_idle_state", {busy, level}, {1'b0, 3'd4});
    qStrobe = 1'b1;
    qData   = 8'h64;
    stop_strobe();
    chk("pp_level", level, 3'd4);
    chk("pp_overflow", overflow, 1'b0);
    drain();

    send(8'hC3);
    stop_strobe();
    repeat (18) @(negedge clk);
    chk("mid_txd_bit3", txd, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("mid_reset_txd", txd, 1'b1);
    chk("mid_reset_busy", {busy, empty, level}, {1'b0, 1'b1, 3'd0});
    repeat (2) @(negedge clk);
    reset = 1'b0;
    send(8'h3C);
    stop_strobe();
    drain();

    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      qStrobe = ($urandom_range(0, 19) < 2);
      qData   = $urandom;
    end
    stop_strobe();
    drain();
    repeat (FRAME) @(negedge clk);
    chk("frames_outstanding", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
